bcd_scan_display: RTL and testbench



---
 rtl/bcd_scan_display.sv | 187 ++++++++++++++++++
 tb/tb_bcd_scan_display.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_display.sv
// bcd_scan_display: multiplexes snapshotted BCD digits onto a 4-digit 7-seg.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zeros.
module bcd_scan_display #(
  parameter int REFRESH_DIV      = 100000,
  parameter bit BLANK_ON_DISABLE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] ones,
  input  logic [3:0] tens,
  input  logic [3:0] hundreds,
  input  logic       error,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic       frame_start
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LP_LAST = CW'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_E    = 7'b0000110;

  typedef enum logic [1:0] {
    D0 = 2'd0,
    D1 = 2'd1,
    D2 = 2'd2,
    D3 = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic          w_tick;
  logic          w_snap;
  logic          w_snap_en;
  logic          r_live;
  logic [3:0]    r_ones;
  logic [3:0]    r_tens;
  logic [3:0]    r_hund;
  logic          r_err;
  logic          w_lz1;
  logic          w_lz2;
  logic          w_blank;
  logic [3:0]    w_an;
  logic [6:0]    w_seg;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;

  function automatic logic [6:0] f_dec(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  assign w_tick = (r_cnt == LP_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= D0;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_tick) begin
      unique case (r_state)
        D0: w_state_nxt = D1;
        D1: w_state_nxt = D2;
        D2: w_state_nxt = D3;
        D3: w_state_nxt = D0;
      endcase
    end
  end

  // With scanning kept alive while disabled, the snapshot stays frozen.
  assign w_snap_en = BLANK_ON_DISABLE || enable;
  assign w_snap    = w_tick && (r_state == D3) && w_snap_en;
  assign frame_start = w_snap && reset;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ones <= '0;
      r_tens <= '0;
      r_hund <= '0;
      r_err  <= 1'b0;
    end else if (w_snap) begin
      r_ones <= ones;
      r_tens <= tens;
      r_hund <= hundreds;
      r_err  <= error;
    end
  end

  // Display stays dark until the scan has made its first move.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_live <= 1'b0;
    end else if (w_tick) begin
      r_live <= 1'b1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  assign w_lz2 = (r_hund == 4'd0);
  assign w_lz1 = w_lz2 && (r_tens == 4'd0);
`else
  assign w_lz2 = 1'b0;
  assign w_lz1 = 1'b0;
`endif

  always_comb begin
    w_an  = 4'b1111;
    w_seg = SEG_OFF;
    unique case (r_state)
      D0: begin
        w_an  = 4'b1110;
        w_seg = f_dec(r_ones);
      end
      D1: begin
        if (!w_lz1) begin
          w_an  = 4'b1101;
          w_seg = f_dec(r_tens);
        end
      end
      D2: begin
        if (!w_lz2) begin
          w_an  = 4'b1011;
          w_seg = f_dec(r_hund);
        end
      end
      D3: begin
        if (r_err) begin
          w_an  = 4'b0111;
          w_seg = SEG_E;
        end
      end
    endcase
  end

  assign w_blank = !r_live || (BLANK_ON_DISABLE && !enable);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_an  <= 4'b1111;
      r_seg <= SEG_OFF;
    end else if (w_blank) begin
      r_an  <= 4'b1111;
      r_seg <= SEG_OFF;
    end else begin
      r_an  <= w_an;
      r_seg <= w_seg;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_bcd_scan_display.sv
// tb_bcd_scan_display: random + directed bench against a cycle-count model.
// Builds with or without LEADING_ZERO_BLANK_EN.
module tb_bcd_scan_display;

  localparam int DIV = 4;
  localparam int FRAME = 4 * DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b1;
  logic [3:0] ones = '0;
  logic [3:0] tens = '0;
  logic [3:0] hundreds = '0;
  logic       error = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;
  logic       frame_start;

  int errs = 0;
  int checks = 0;

  bcd_scan_display #(
    .REFRESH_DIV(DIV),
    .BLANK_ON_DISABLE(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .ones(ones),
    .tens(tens),
    .hundreds(hundreds),
    .error(error),
    .seg(seg),
    .an(an),
    .dp(dp),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // Model: k = clock edges since reset release; slot and frame follow by division.
  int         k = 0;
  bit         m_started = 0;
  logic [3:0] m_o, m_t, m_h;
  logic       m_e;
  logic [3:0] e_an = 4'hF;
  logic [6:0] e_seg = 7'h7F;
  bit         e_segv = 1;
  bit         lzb;

  initial begin
`ifdef LEADING_ZERO_BLANK_EN
    lzb = 1;
`else
    lzb = 0;
`endif
  end

  always @(posedge clk) begin
    m_started = 1;
    if (!reset) begin
      k = 0;
      m_o = 0; m_t = 0; m_h = 0; m_e = 0;
      e_an = 4'hF; e_seg = 7'h7F; e_segv = 1;
    end else begin
      k = k + 1;
      e_an = 4'hF; e_seg = 7'h7F; e_segv = 1;
      if (k - 1 >= DIV) begin
        if (!enable) begin
          e_segv = 0;
        end else begin
          case (((k - 1) / DIV) % 4)
            0: begin e_an = 4'b1110; e_seg = dec(m_o); end
            1: if (!(lzb && m_h == 0 && m_t == 0)) begin
                 e_an = 4'b1101; e_seg = dec(m_t);
               end else e_segv = 0;
            2: if (!(lzb && m_h == 0)) begin
                 e_an = 4'b1011; e_seg = dec(m_h);
               end else e_segv = 0;
            default: if (m_e) begin
                 e_an = 4'b0111; e_seg = 7'b0000110;
               end else e_segv = 0;
          endcase
        end
      end
      if (k % FRAME == 0) begin
        m_o = ones; m_t = tens; m_h = hundreds; m_e = error;
      end
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      logic e_fs;
      e_fs = reset && ((k + 1) % FRAME == 0);
      checks++;
      if (an !== e_an) begin
        errs++;
        $display("FAIL an t=%0t k=%0d got=%b exp=%b", $time, k, an, e_an);
      end
      if (e_segv) begin
        checks++;
        if (seg !== e_seg) begin
          errs++;
          $display("FAIL seg t=%0t k=%0d got=%b exp=%b", $time, k, seg, e_seg);
        end
      end
      checks++;
      if (dp !== 1'b1) begin
        errs++;
        $display("FAIL dp t=%0t got=%b exp=1", $time, dp);
      end
      checks++;
      if (frame_start !== e_fs) begin
        errs++;
        $display("FAIL frame_start t=%0t k=%0d got=%b exp=%b",
                 $time, k, frame_start, e_fs);
      end
    end
  end

  task automatic chk(input string nm, input logic [6:0] got,
                     input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%b exp=%b", nm, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fs(input string nm);
    bit seen;
    seen = 0;
    for (int i = 0; i < 3 * FRAME && !seen; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      errs++;
      $display("FAIL %s no frame_start got=0 exp=1", nm);
    end
  endtask

  initial begin
    int nfs;
    // Reset and first frame
    step(3);
    chk("rst_an", {3'b0, an}, 7'h0F);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", {6'b0, dp}, 7'h01);
    #1 reset = 1'b1;
    ones = 4'd3; tens = 4'd2; hundreds = 4'd1;
    step(1);
    chk("post_rst_an", {3'b0, an}, 7'h0F);
    chk("post_rst_seg", seg, 7'h7F);
    wait_fs("first_frame");

    // Rotating 3/2/1
    wait_fs("rot");
    step(2);
    chk("rot_d0_an", {3'b0, an}, 7'b0001110);
    chk("rot_d0_seg", seg, 7'b0110000);
    step(4);
    chk("rot_d1_an", {3'b0, an}, 7'b0001101);
    chk("rot_d1_seg", seg, 7'b0100100);
    step(4);
    chk("rot_d2_an", {3'b0, an}, 7'b0001011);
    chk("rot_d2_seg", seg, 7'b1111001);
    step(4);
    chk("rot_d3_an", {3'b0, an}, 7'h0F);

    // Mid-frame change of ones
    #1 ones = 4'd4;
    wait_fs("mid");
    step(2);
    chk("mid_d0_old", seg, 7'b0011001);
    step(4);
    #1 ones = 4'd5;
    step(12);
    chk("mid_d0_new_an", {3'b0, an}, 7'b0001110);
    chk("mid_d0_new_seg", seg, 7'b0010010);

    // Error with zero digits
    #1 ones = 0; tens = 0; hundreds = 0; error = 1'b1;
    wait_fs("err");
    step(2);
    chk("err_d0_seg", seg, 7'b1000000);
    step(4);
    if (lzb) chk("err_d1_an", {3'b0, an}, 7'h0F);
    else chk("err_d1_seg", seg, 7'b1000000);
    step(8);
    chk("err_d3_an", {3'b0, an}, 7'b0000111);
    chk("err_d3_seg", seg, 7'b0000110);

    // Dash, then disable
    #1 error = 1'b0; ones = 4'b1011; tens = 4'd7; hundreds = 4'd9;
    wait_fs("dash");
    step(2);
    chk("dash_seg", seg, 7'b0111111);
    #1 enable = 1'b0;
    step(1);
    chk("dis_an", {3'b0, an}, 7'h0F);
    nfs = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      step(1);
      if (frame_start === 1'b1) nfs++;
    end
    chk("dis_fs_count", 7'(nfs), 7'd3);
    #1 enable = 1'b1;

    // Reset during D2
    wait_fs("rst_mid");
    step(10);
    chk("rstmid_d2_an", {3'b0, an}, 7'b0001011);
    #1 reset = 1'b0;
    step(1);
    chk("rstmid_an", {3'b0, an}, 7'h0F);
    chk("rstmid_seg", seg, 7'h7F);
    step(1);
    #1 reset = 1'b1;
    step(2);
    chk("rstrel_an", {3'b0, an}, 7'h0F);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      #1;
      if ($urandom_range(0, 3) == 0) ones = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) tens = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) hundreds = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) begin
        tens = 0; hundreds = 0;
      end
      if ($urandom_range(0, 11) == 0) error = ~error;
      if ($urandom_range(0, 29) == 0) enable = ~enable;
      reset = ($urandom_range(0, 199) != 0);
      step(1);
    end
    #1 reset = 1'b1; enable = 1'b1;
    step(2 * FRAME);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
